// File: rtl/memory_dumper_if.sv
// memory_dumper_if: memory read port plus UART transmit byte stream used by the dumper
interface memory_dumper_if;
  logic [31:0] mem_out_addr;
  logic        mem_out_valid;
  logic [31:0] mem_out_data;
  logic        mem_out_ready;
  logic [7:0]  uart_in_data;
  logic        uart_in_valid;
  logic        uart_in_ready;
  modport master (
    output mem_out_addr, mem_out_valid, uart_in_data, uart_in_valid,
    input  mem_out_data, mem_out_ready, uart_in_ready
  );
  modport slave (
    input  mem_out_addr, mem_out_valid, uart_in_data, uart_in_valid,
    output mem_out_data, mem_out_ready, uart_in_ready
  );
endinterface

// File: rtl/memory_dumper.sv
// memory_dumper: reads a block of words from memory and streams each word out as four UART bytes
module memory_dumper #(
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [31:0]    base_addr,
  input  logic [31:0]    word_count,
  output logic           busy,
  output logic           completed,
  memory_dumper_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;
  state_t state, next;
  logic [31:0] addr, remaining, word_buf;
  logic [1:0] byte_idx, sel;
  logic mem_hs, byte_hs, word_end;
  assign mem_hs   = state == READ && bus.mem_out_ready;
  assign byte_hs  = state == SEND && bus.uart_in_ready;
  assign word_end = byte_hs && byte_idx == 2'd3;
  assign sel      = MSB_FIRST ? 2'd3 - byte_idx : byte_idx;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? (word_count == 32'd0 ? DONE : READ) : IDLE;
      READ:    next = mem_hs ? SEND : READ;
      SEND:    next = word_end ? (remaining == 32'd1 ? DONE : READ) : SEND;
      default: next = IDLE;
    endcase
  end
  assign busy              = state != IDLE;
  assign completed         = state == DONE;
  assign bus.mem_out_valid = state == READ;
  assign bus.mem_out_addr  = addr;
  assign bus.uart_in_valid = state == SEND;
  assign bus.uart_in_data  = state == SEND ? word_buf[{sel, 3'b000} +: 8] : 8'd0;
  // remaining is only decremented on a word finish, which needs remaining >= 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= 32'd0;
      remaining <= 32'd0;
      word_buf  <= 32'd0;
      byte_idx  <= 2'd0;
    end else begin
      state <= next;
      if (state == IDLE && start) begin
        addr      <= base_addr;
        remaining <= word_count;
      end
      if (mem_hs) begin
        word_buf <= bus.mem_out_data;
        byte_idx <= 2'd0;
      end
      if (byte_hs) byte_idx <= byte_idx + 2'd1;
      if (word_end) begin
        addr      <= addr + ADDR_STEP;
        remaining <= remaining - 32'd1;
      end
    end
  end
endmodule
